// File: rtl/sky130io_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sky130io_gpio_pkg
// Description : Shared types and constants for the gpiov2 bank controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sky130io_gpio_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PWRUP   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_FREEZE  = 3'd4,
        ST_THAW    = 3'd5
    } gpio_state_t;

    localparam int CFG_W = 10;

    localparam int c_off_dm          = 0;
    localparam int c_off_slow        = 3;
    localparam int c_off_vtrip_sel   = 4;
    localparam int c_off_inp_dis     = 5;
    localparam int c_off_ib_mode_sel = 6;
    localparam int c_off_analog_en   = 7;
    localparam int c_off_analog_sel  = 8;
    localparam int c_off_analog_pol  = 9;

    // Input buffer disabled, everything else off.
    localparam logic [CFG_W-1:0] c_cfg_rst = 10'h020;

    function automatic int unsigned f_cnt_w(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sky130io_gpio_chan.sv
`default_nettype none
// ============================================================================
// Module      : sky130io_gpio_chan
// Description : One pad channel: config register, out/oe registers and
//               input synchroniser with inp_dis gating.
// Revision    : 1.0 - initial release
// ============================================================================
module sky130io_gpio_chan
    import sky130io_gpio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cfg_we,
    input  logic [CFG_W-1:0] i_cfg_data,
    input  logic             i_core_out,
    input  logic             i_core_oe,
    input  logic             i_oe_pass,
    input  logic             i_pad_in,
    output logic [2:0]       o_dm,
    output logic             o_slow,
    output logic             o_vtrip_sel,
    output logic             o_inp_dis,
    output logic             o_ib_mode_sel,
    output logic             o_analog_en,
    output logic             o_analog_sel,
    output logic             o_analog_pol,
    output logic             o_pad_out,
    output logic             o_pad_oe_n,
    output logic             o_core_in
);

    logic [CFG_W-1:0] r_cfg;
    logic             r_out;
    logic             r_oe;
    logic             r_sync1;
    logic             r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg   <= c_cfg_rst;
            r_out   <= 1'b0;
            r_oe    <= 1'b0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            if (i_cfg_we) begin
                r_cfg <= i_cfg_data;
            end
            r_out   <= i_core_out;
            r_oe    <= i_core_oe;
            r_sync1 <= i_pad_in;
            r_sync2 <= r_sync1;
        end
    end

    assign o_dm          = r_cfg[c_off_dm +: 3];
    assign o_slow        = r_cfg[c_off_slow];
    assign o_vtrip_sel   = r_cfg[c_off_vtrip_sel];
    assign o_inp_dis     = r_cfg[c_off_inp_dis];
    assign o_ib_mode_sel = r_cfg[c_off_ib_mode_sel];
    assign o_analog_en   = r_cfg[c_off_analog_en];
    assign o_analog_sel  = r_cfg[c_off_analog_sel];
    assign o_analog_pol  = r_cfg[c_off_analog_pol];

    assign o_pad_out  = r_out;
    // Driver stays tristated until the sequencer lets the output through.
    assign o_pad_oe_n = ~(r_oe & i_oe_pass);
    assign o_core_in  = r_sync2 & ~o_inp_dis;

endmodule
`default_nettype wire

// File: rtl/sky130io_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sky130io_gpio_ctrl
// Description : gpiov2 bank controller: power-up/hold sequencer, config
//               write port and per-channel pad datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module sky130io_gpio_ctrl
    import sky130io_gpio_pkg::*;
#(
    parameter int NCHAN     = 8,
    parameter int PGOOD_CYC = 16,
    parameter int HOLD_CYC  = 4,
    parameter int AW        = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pgood,
    input  logic               freeze,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [CFG_W-1:0]   cfg_data,
    output logic               cfg_err,
    output logic               active,
    input  logic [NCHAN-1:0]   core_out,
    input  logic [NCHAN-1:0]   core_oe,
    output logic [NCHAN-1:0]   core_in,
    output logic               pad_enable_h,
    output logic               pad_enable_inp_h,
    output logic [NCHAN-1:0]   pad_hld_h_n,
    output logic [NCHAN-1:0]   pad_out,
    output logic [NCHAN-1:0]   pad_oe_n,
    output logic [NCHAN-1:0]   pad_slow,
    output logic [NCHAN-1:0]   pad_vtrip_sel,
    output logic [NCHAN-1:0]   pad_inp_dis,
    output logic [NCHAN-1:0]   pad_ib_mode_sel,
    output logic [NCHAN-1:0]   pad_analog_en,
    output logic [NCHAN-1:0]   pad_analog_sel,
    output logic [NCHAN-1:0]   pad_analog_pol,
    output logic [3*NCHAN-1:0] pad_dm,
    input  logic [NCHAN-1:0]   pad_in
);

    localparam int                 c_cnt_w     = f_cnt_w(PGOOD_CYC, HOLD_CYC);
    localparam logic [c_cnt_w-1:0] c_pg_last   = c_cnt_w'(PGOOD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = {c_cnt_w{1'b1}};
    localparam int unsigned        c_nchan     = NCHAN;

    gpio_state_t        r_state;
    gpio_state_t        w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_active;
    logic               r_enable_h;
    logic               r_enable_inp_h;
    logic               r_oe_pass;
    logic               r_cfg_ready;
    logic               r_cfg_err;
    logic               w_cfg_fire;
    logic               w_addr_ok;
    logic               w_counting;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:     if (pgood) w_state_nxt = ST_PWRUP;
            ST_PWRUP:   if (r_cnt == c_pg_last) w_state_nxt = ST_RELEASE;
            ST_RELEASE: if (r_cnt == c_hold_last) w_state_nxt = ST_RUN;
            ST_RUN:     if (freeze) w_state_nxt = ST_FREEZE;
            ST_FREEZE:  if (!freeze) w_state_nxt = ST_THAW;
            ST_THAW: begin
                if (freeze) begin
                    w_state_nxt = ST_FREEZE;
                end else if (r_cnt == c_hold_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default:    w_state_nxt = ST_OFF;
        endcase
        // Supply loss overrides every other request.
        if (!pgood) begin
            w_state_nxt = ST_OFF;
        end
    end

    // Counter only runs while dwelling in a timed state; any entry reloads 0.
    assign w_counting = (w_state_nxt == r_state) &&
                        (r_state inside {ST_PWRUP, ST_RELEASE, ST_THAW});
    assign w_cnt_nxt  = !w_counting         ? '0 :
                        (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    assign w_cfg_fire = cfg_valid & r_cfg_ready;
    assign w_addr_ok  = (32'(cfg_addr) < c_nchan);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_OFF;
            r_cnt          <= '0;
            r_active       <= 1'b0;
            r_enable_h     <= 1'b0;
            r_enable_inp_h <= 1'b0;
            r_oe_pass      <= 1'b0;
            r_cfg_ready    <= 1'b1;
            r_cfg_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_active       <= (w_state_nxt == ST_RUN);
            r_enable_h     <= (w_state_nxt != ST_OFF);
            r_enable_inp_h <= (w_state_nxt inside {ST_RELEASE, ST_RUN, ST_FREEZE, ST_THAW});
            r_oe_pass      <= (w_state_nxt inside {ST_RUN, ST_FREEZE, ST_THAW});
            r_cfg_ready    <= (w_state_nxt inside {ST_OFF, ST_RUN, ST_FREEZE});
            if (w_cfg_fire && !w_addr_ok) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    assign active           = r_active;
    assign cfg_ready        = r_cfg_ready;
    assign cfg_err          = r_cfg_err;
    assign pad_enable_h     = r_enable_h;
    assign pad_enable_inp_h = r_enable_inp_h;
    // Pads are released from hold exactly when the bank is running.
    assign pad_hld_h_n      = {NCHAN{r_active}};

    generate
        for (genvar i = 0; i < NCHAN; i++) begin : g_chan
            logic w_we;
            assign w_we = w_cfg_fire && w_addr_ok && (cfg_addr == AW'(i));

            sky130io_gpio_chan u_chan (
                .clk           (clk),
                .rst           (rst),
                .i_cfg_we      (w_we),
                .i_cfg_data    (cfg_data),
                .i_core_out    (core_out[i]),
                .i_core_oe     (core_oe[i]),
                .i_oe_pass     (r_oe_pass),
                .i_pad_in      (pad_in[i]),
                .o_dm          (pad_dm[3*i +: 3]),
                .o_slow        (pad_slow[i]),
                .o_vtrip_sel   (pad_vtrip_sel[i]),
                .o_inp_dis     (pad_inp_dis[i]),
                .o_ib_mode_sel (pad_ib_mode_sel[i]),
                .o_analog_en   (pad_analog_en[i]),
                .o_analog_sel  (pad_analog_sel[i]),
                .o_analog_pol  (pad_analog_pol[i]),
                .o_pad_out     (pad_out[i]),
                .o_pad_oe_n    (pad_oe_n[i]),
                .o_core_in     (core_in[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
